// File: rtl/dcache_wb_dm_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_wb_dm_pkg;

    localparam int WORD_W     = 32;
    localparam int BLOCK_W    = 128;
    localparam int OFF_W      = 2;   // word offset within a 4-word block
    localparam int ADDR_W     = 30;  // word address from the core
    localparam int BADDR_W    = 28;  // block address towards memory
    localparam int NUM_BLOCKS = 8;
    localparam int IDX_W      = 3;
    localparam int TAG_W      = BADDR_W - IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_e;

    // Update requested of the line array at the next rising edge.
    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_WORD = 2'd1,  // store one word, mark line dirty
        WR_FILL = 2'd2   // load whole block from memory, mark line clean
    } wr_mode_e;

    // Pick one 32-bit word out of a block; word 0 lives in the low bits.
    function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFF_W-1:0]   off);
        return blk[off*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_wb_dm_line_array.sv
// Data, tag, valid and dirty storage for the cache lines: one combinational
// read port and one synchronous write port sharing the same index.
module dcache_line_array
    import dcache_wb_dm_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int IDX_W      = 3,
    parameter int TAG_W      = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   idx,
    input  wr_mode_e           wr_mode,
    input  logic [OFF_W-1:0]   wr_off,
    input  logic [WORD_W-1:0]  wr_word,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_block,
    output logic [BLOCK_W-1:0] rd_block,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    output logic               rd_dirty
);

    logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid_q, valid_d;
    logic [NUM_BLOCKS-1:0] dirty_q, dirty_d;

    // Next-state of the per-line status bits.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        valid_d = valid_q;
        dirty_d = dirty_q;
        case (wr_mode)
            WR_WORD: dirty_d[idx] = 1'b1;
            WR_FILL: begin
                valid_d[idx] = 1'b1;
                dirty_d[idx] = 1'b0;
            end
            default: ;
        endcase
    end

    // Status bits: cleared asynchronously so the cache comes up empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Data and tag storage; contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        // NOTE: the arrays have no reset so they can map onto RAM; valid bits guard them.
        case (wr_mode)
            WR_WORD: data_q[idx][wr_off*WORD_W +: WORD_W] <= wr_word;
            WR_FILL: begin
                data_q[idx] <= fill_block;
                tag_q[idx]  <= fill_tag;
            end
            default: ;
        endcase
    end

    assign rd_block = data_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];

endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word blocks.
// Stalls the core on a miss, evicts dirty victims, then refills from memory.
module dcache_wb_dm
    import dcache_wb_dm_pkg::*;
#(
    parameter int NUM_BLOCKS = 8,
    parameter int IDX_W      = 3,
    parameter int TAG_W      = 28 - IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               proc_read,
    input  logic               proc_write,
    input  logic [29:0]        proc_addr,
    input  logic [31:0]        proc_wdata,
    output logic               proc_stall,
    output logic [31:0]        proc_rdata,
    output logic               mem_read,
    output logic               mem_write,
    output logic [27:0]        mem_addr,
    output logic [127:0]       mem_wdata,
    input  logic [127:0]       mem_rdata,
    input  logic               mem_ready
);

    state_e               state_q, state_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    wr_mode_e             wr_mode;

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [OFF_W-1:0]     off;
    logic [BLOCK_W-1:0]   line_block;
    logic [TAG_W-1:0]     line_tag;
    logic                 line_valid;
    logic                 line_dirty;
    logic                 req;
    logic                 hit;

    assign off = proc_addr[1:0];
    assign idx = proc_addr[IDX_W+1:2];
    assign tag = proc_addr[29:IDX_W+2];
    assign req = proc_read | proc_write;
    assign hit = line_valid & (line_tag == tag);

    dcache_line_array #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx),
        .wr_mode    (wr_mode),
        .wr_off     (off),
        .wr_word    (proc_wdata),
        .fill_tag   (tag),
        .fill_block (mem_rdata),
        .rd_block   (line_block),
        .rd_tag     (line_tag),
        .rd_valid   (line_valid),
        .rd_dirty   (line_dirty)
    );

    // Miss FSM: next state, registered memory request strobes, array update.
    // Request strobes are registered so they always fall the cycle after
    // mem_ready; the cycle spent in ALLOCATE with mem_read_q low after a
    // writeback is the mandatory idle gap between the two transfers.
    always_comb begin
        state_d     = state_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        wr_mode     = WR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (proc_write) wr_mode = WR_WORD;
                    end else if (line_valid && line_dirty) begin
                        state_d     = ST_WRITEBACK;
                        mem_write_d = 1'b1;
                    end else begin
                        state_d    = ST_ALLOCATE;
                        mem_read_d = 1'b1;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (mem_ready) state_d     = ST_ALLOCATE;
                else           mem_write_d = 1'b1;
            end
            ST_ALLOCATE: begin
                if (mem_read_q && mem_ready) begin
                    wr_mode = WR_FILL;
                    state_d = ST_IDLE;
                end else begin
                    mem_read_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and memory-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    // Memory address/data follow the state; zero while idle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_WRITEBACK: begin
                mem_addr  = {line_tag, idx};
                mem_wdata = line_block;
            end
            ST_ALLOCATE: mem_addr = proc_addr[29:2];
            default: ;
        endcase
    end

    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign proc_stall = (state_q != ST_IDLE) | (req & ~hit);
    // Gated by hit so the output is a clean zero while lines are invalid.
    assign proc_rdata = hit ? word_sel(line_block, off) : '0;

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Directed bench for dcache_wb_dm with a fixed-latency block memory model.
module tb_dcache_wb_dm;

    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int errors = 0;
    int checks = 0;

    // Memory-side observations.
    int           rd_reqs = 0, wr_reqs = 0, both_cnt = 0, cnt = 0;
    logic         prev_rd = 1'b0, prev_wr = 1'b0;
    logic [27:0]  last_rd_addr = '0, last_wr_addr = '0;
    logic [127:0] last_wdata = '0;

    logic [31:0]  rd;
    int           lat;

    always #5 clk = ~clk;

    dcache_wb_dm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Refill pattern: word i of block a is {a, 2'b00, i}.
    function automatic logic [127:0] blk(input logic [27:0] a);
        logic [127:0] b;
        for (int i = 0; i < 4; i++) b[i*32 +: 32] = {a, 2'b00, 2'(i)};
        return b;
    endfunction

    // Memory model: ready pulses LAT cycles after a request is first seen.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0; mem_ready = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0;
            end else begin
                if (mem_read && mem_write) both_cnt++;
                if (mem_read && !prev_rd) begin rd_reqs++; last_rd_addr = mem_addr; end
                if (mem_write && !prev_wr) begin
                    wr_reqs++; last_wr_addr = mem_addr; last_wdata = mem_wdata;
                end
                prev_rd = mem_read;
                prev_wr = mem_write;
                if (mem_ready) begin
                    mem_ready = 1'b0; cnt = 0;
                end else if (mem_read || mem_write) begin
                    cnt++;
                    if (cnt == LAT) begin
                        mem_ready = 1'b1;
                        mem_rdata = blk(mem_addr);
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // One core access; lat counts cycles with proc_stall high.
    task automatic access(input bit wr, input logic [29:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output int stalls);
        @(negedge clk);
        proc_read = !wr; proc_write = wr; proc_addr = a; proc_wdata = d;
        stalls = 0;
        #1;
        while (proc_stall && stalls < 200) begin
            @(negedge clk); #1;
            stalls++;
        end
        if (stalls >= 200) check("access_timeout", 1, 0);
        rdata = proc_rdata;
        @(posedge clk); #1;
        proc_read = 1'b0; proc_write = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; proc_read = 1'b0; proc_write = 1'b0;
        proc_addr = '0; proc_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", proc_stall, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", proc_rdata, 0);
        #2 rst_n = 1'b1;

        // Cold read miss on block 1.
        access(0, 30'h0000004, 0, rd, lat);
        check("cold_lat", lat, LAT + 1);
        check("cold_rdata", rd, 32'h0000_0010);
        check("cold_rd_reqs", rd_reqs, 1);
        check("cold_rd_addr", last_rd_addr, 28'h0000001);
        check("cold_wr_reqs", wr_reqs, 0);

        // Read hit, word 1.
        access(0, 30'h0000005, 0, rd, lat);
        check("hit_lat", lat, 0);
        check("hit_rdata", rd, 32'h0000_0011);

        // Write hit then read back, no memory traffic.
        access(1, 30'h0000006, 32'hDEADBEEF, rd, lat);
        check("whit_lat", lat, 0);
        access(0, 30'h0000006, 0, rd, lat);
        check("whit_rd_lat", lat, 0);
        check("whit_rdata", rd, 32'hDEADBEEF);
        check("whit_rd_reqs", rd_reqs, 1);
        check("whit_wr_reqs", wr_reqs, 0);

        // Dirty eviction: same index 1, tag 1 (block 9).
        access(0, 30'h0000024, 0, rd, lat);
        check("evict_lat", lat, 2 * LAT + 2);
        check("evict_wr_reqs", wr_reqs, 1);
        check("evict_wr_addr", last_wr_addr, 28'h0000001);
        check("evict_wdata_w2", last_wdata[95:64], 32'hDEADBEEF);
        check("evict_wdata_w0", last_wdata[31:0], 32'h0000_0010);
        check("evict_rd_reqs", rd_reqs, 2);
        check("evict_rd_addr", last_rd_addr, 28'h0000009);
        check("evict_rdata", rd, 32'h0000_0090);

        // Clean miss: block 9 is clean, so only a refill.
        access(0, 30'h0000004, 0, rd, lat);
        check("clean_lat", lat, LAT + 1);
        check("clean_wr_reqs", wr_reqs, 1);
        check("clean_rd_reqs", rd_reqs, 3);
        check("clean_rdata", rd, 32'h0000_0010);

        // Write miss allocates block 0xA, then hits on the next cycle.
        access(1, 30'h0000028, 32'h12345678, rd, lat);
        check("wmiss_lat", lat, LAT + 1);
        check("wmiss_rd_addr", last_rd_addr, 28'h000000A);
        access(0, 30'h0000028, 0, rd, lat);
        check("wmiss_rdata0", rd, 32'h12345678);
        access(0, 30'h0000029, 0, rd, lat);
        check("wmiss_rdata1", rd, 32'h0000_00A1);
        check("wmiss_wr_reqs", wr_reqs, 1);

        // Reset while refilling block 0x11.
        @(negedge clk);
        proc_read = 1'b1; proc_addr = 30'h0000044;
        repeat (4) @(negedge clk);
        #2;
        check("mid_mem_read", mem_read, 1);
        rst_n = 1'b0; proc_read = 1'b0;
        #1;
        check("rstmid_mem_read", mem_read, 0);
        check("rstmid_mem_write", mem_write, 0);
        check("rstmid_stall", proc_stall, 0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        access(0, 30'h0000044, 0, rd, lat);
        check("post_rst_lat", lat, LAT + 1);
        check("post_rst_rd_addr", last_rd_addr, 28'h0000011);
        check("post_rst_rdata", rd, 32'h0000_0110);
        // Valid bits were cleared, so a formerly resident line misses too.
        access(0, 30'h0000028, 0, rd, lat);
        check("post_rst_lat2", lat, LAT + 1);

        check("never_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
